param_deserializer: RTL and testbench

Parametrised serial-to-parallel receiver for the self-test link. It hunts for a configurable sync pattern on a qualified serial bit stream, then assembles a fixed number of WORD_W-bit words per frame. Each completed word is presented with a one-cycle valid strobe, a word index and an end-of-frame flag. Bit order is selectable, and a bit-valid qualifier tolerates gaps in the stream.

---
 rtl/param_deserializer_if.sv | 27 ++
 rtl/param_deserializer.sv | 145 ++++++++++++++
 tb/tb_param_deserializer.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/param_deserializer_if.sv
// Serial-link bundle for param_deserializer: qualified serial input plus word-level outputs.
// master drives the bit stream, slave is the deserializer.
interface param_deserializer_if #(
    parameter int WORD_W    = 8,
    parameter int NUM_WORDS = 4
);
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    logic              data_in;
    logic              bit_valid;
    logic [WORD_W-1:0] data_out;
    logic              data_valid;
    logic [IDX_W-1:0]  word_idx;
    logic              frame_done;
    logic              sync_lock;
    logic              parity_err;

    modport master (
        output data_in, bit_valid,
        input  data_out, data_valid, word_idx, frame_done, sync_lock, parity_err
    );

    modport slave (
        input  data_in, bit_valid,
        output data_out, data_valid, word_idx, frame_done, sync_lock, parity_err
    );
endinterface

// File: rtl/param_deserializer.sv
// Sync-hunting serial-to-parallel receiver: NUM_WORDS words of WORD_W bits per frame.
// Optional per-word even parity check enabled by defining PARITY_CHK_EN.
module param_deserializer #(
    parameter int                 WORD_W       = 8,
    parameter int                 NUM_WORDS    = 4,
    parameter int                 SYNC_W       = 4,
    parameter logic [SYNC_W-1:0]  SYNC_PATTERN = 4'b1010,
    parameter bit                 MSB_FIRST    = 1'b1
) (
    input  logic                  t_clk,
    input  logic                  rst,
    param_deserializer_if.slave   link
);
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
`ifdef PARITY_CHK_EN
    localparam int BPW = WORD_W + 1;
`else
    localparam int BPW = WORD_W;
`endif
    localparam int BCW = $clog2(BPW + 1);
    localparam int FCW = $clog2(SYNC_W + 1);

    localparam logic [BCW-1:0]   LAST_BIT  = BCW'(BPW - 1);
    localparam logic [BCW-1:0]   DATA_BITS = BCW'(WORD_W);
    localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(NUM_WORDS - 1);
    localparam logic [FCW-1:0]   FILL_FULL = FCW'(SYNC_W);
    localparam logic [FCW-1:0]   FILL_ARM  = FCW'(SYNC_W - 1);

    localparam logic [0:0] HUNT = 1'b0;
    localparam logic [0:0] RECV = 1'b1;

    logic [0:0]        state;
    logic [SYNC_W-1:0] sync_sr;
    logic [FCW-1:0]    fill_cnt;
    logic [BCW-1:0]    bit_cnt;
    logic [IDX_W-1:0]  word_cnt;
    logic [WORD_W-1:0] word_sr;

    logic [WORD_W-1:0] data_out_q;
    logic              data_valid_q;
    logic [IDX_W-1:0]  word_idx_q;
    logic              frame_done_q;

    logic [SYNC_W-1:0] sync_next;
    logic [WORD_W-1:0] word_next;
    logic [WORD_W-1:0] word_done;
    logic              sync_hit;

    if (SYNC_W == 1) begin : g_sync_one
        always_comb sync_next = link.data_in;
    end else begin : g_sync_shift
        always_comb sync_next = {sync_sr[SYNC_W-2:0], link.data_in};
    end

    if (WORD_W == 1) begin : g_word_one
        always_comb word_next = link.data_in;
    end else if (MSB_FIRST) begin : g_word_msb
        always_comb word_next = {word_sr[WORD_W-2:0], link.data_in};
    end else begin : g_word_lsb
        always_comb word_next = {link.data_in, word_sr[WORD_W-1:1]};
    end

    // Match needs a full window of fresh bits so stale register contents never complete a sync.
    always_comb sync_hit = (sync_next == SYNC_PATTERN) && (fill_cnt >= FILL_ARM);

`ifdef PARITY_CHK_EN
    logic parity_err_q;

    // The parity bit is the last bit of the word, so the data is already fully assembled.
    always_comb word_done = word_sr;

    always_ff @(posedge t_clk or posedge rst) begin
        if (rst) begin
            parity_err_q <= 1'b0;
        end else if (link.bit_valid && state == RECV && bit_cnt == LAST_BIT) begin
            parity_err_q <= ^{word_sr, link.data_in};
        end else begin
            parity_err_q <= 1'b0;
        end
    end

    assign link.parity_err = parity_err_q;
`else
    always_comb word_done = word_next;

    assign link.parity_err = 1'b0;
`endif

    always_ff @(posedge t_clk or posedge rst) begin
        if (rst) begin
            state        <= HUNT;
            sync_sr      <= '0;
            fill_cnt     <= '0;
            bit_cnt      <= '0;
            word_cnt     <= '0;
            word_sr      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            word_idx_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            if (link.bit_valid) begin
                case (state)
                    HUNT: begin
                        sync_sr <= sync_next;
                        if (fill_cnt != FILL_FULL) fill_cnt <= fill_cnt + 1'b1;
                        if (sync_hit) begin
                            state    <= RECV;
                            bit_cnt  <= '0;
                            word_cnt <= '0;
                        end
                    end
                    default: begin
                        if (bit_cnt < DATA_BITS) word_sr <= word_next;
                        if (bit_cnt == LAST_BIT) begin
                            data_out_q   <= word_done;
                            data_valid_q <= 1'b1;
                            word_idx_q   <= word_cnt;
                            bit_cnt      <= '0;
                            if (word_cnt == LAST_WORD) begin
                                frame_done_q <= 1'b1;
                                state        <= HUNT;
                                sync_sr      <= '0;
                                fill_cnt     <= '0;
                                word_cnt     <= '0;
                            end else begin
                                word_cnt <= word_cnt + 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign link.data_out   = data_out_q;
    assign link.data_valid = data_valid_q;
    assign link.word_idx   = word_idx_q;
    assign link.frame_done = frame_done_q;
    assign link.sync_lock  = (state == RECV);
endmodule

// File: tb/tb_param_deserializer.sv
// Bench for param_deserializer: default config (A) and 12-bit LSB-first, 2-word config (B),
// each checked every cycle against a stream-scanning reference model.
module tb_param_deserializer;
`ifdef PARITY_CHK_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    typedef struct packed {
        bit        valid;
        bit [15:0] value;
        bit [7:0]  idx;
        bit        fd;
        bit        pe;
        bit        lock;
    } res_t;

    logic t_clk;
    logic rst;

    param_deserializer_if a_if ();
    param_deserializer_if #(.WORD_W(12), .NUM_WORDS(2)) b_if ();

    param_deserializer dut_a (
        .t_clk (t_clk),
        .rst   (rst),
        .link  (a_if.slave)
    );

    param_deserializer #(
        .WORD_W    (12),
        .NUM_WORDS (2),
        .MSB_FIRST (1'b0)
    ) dut_b (
        .t_clk (t_clk),
        .rst   (rst),
        .link  (b_if.slave)
    );

    initial t_clk = 1'b0;
    always #5 t_clk = ~t_clk;

    int n_assert = 0;
    int n_fail   = 0;
    int dv_seen  = 0;
    int pe_seen  = 0;

    bit          hist_a[$];
    bit          hist_b[$];
    logic [15:0] exp_data[2];
    logic [15:0] exp_idx[2];
    logic        exp_lock[2];

    // Reference: scan the whole stream since reset, locating sync windows and word boundaries by position.
    function automatic res_t scan(input bit q[$], input int ww, input int nw, input bit msbf);
        res_t     r;
        int       bpw;
        int       n;
        bit       lock;
        int       hs;
        int       ps;
        int       k;
        int       w;
        int       base;
        bit [3:0] win;
        bit       x;
        r    = '0;
        bpw  = ww + PAR;
        n    = q.size();
        lock = 1'b0;
        hs   = 0;
        ps   = 0;
        for (int i = 0; i < n; i++) begin
            r.valid = 1'b0;
            r.fd    = 1'b0;
            r.pe    = 1'b0;
            if (!lock) begin
                if (i - hs + 1 >= 4) begin
                    for (int j = 0; j < 4; j++) win[3-j] = q[i-3+j];
                    if (win == 4'b1010) begin
                        lock = 1'b1;
                        ps   = i + 1;
                    end
                end
            end else begin
                k = i - ps;
                if (k % bpw == bpw - 1) begin
                    w       = k / bpw;
                    base    = ps + w * bpw;
                    r.valid = 1'b1;
                    r.idx   = 8'(w);
                    r.value = '0;
                    x       = 1'b0;
                    for (int j = 0; j < ww; j++) begin
                        if (msbf) r.value[ww-1-j] = q[base+j];
                        else      r.value[j]      = q[base+j];
                        x = x ^ q[base+j];
                    end
                    if (PAR == 1) r.pe = x ^ q[base+ww];
                    if (w == nw - 1) begin
                        r.fd = 1'b1;
                        lock = 1'b0;
                        hs   = i + 1;
                    end
                end
            end
        end
        r.lock = lock;
        return r;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int u, input bit v, input bit d);
        res_t        r;
        logic        e_dv, e_fd, e_pe;
        logic        o_dv, o_fd, o_pe, o_lk;
        logic [15:0] o_do, o_ix;
        if (u == 0) begin
            a_if.data_in = d; a_if.bit_valid = v; b_if.bit_valid = 1'b0;
        end else begin
            b_if.data_in = d; b_if.bit_valid = v; a_if.bit_valid = 1'b0;
        end
        @(posedge t_clk);
        #1;
        e_dv = 1'b0; e_fd = 1'b0; e_pe = 1'b0;
        if (v) begin
            if (u == 0) begin
                hist_a.push_back(d);
                r = scan(hist_a, 8, 4, 1'b1);
            end else begin
                hist_b.push_back(d);
                r = scan(hist_b, 12, 2, 1'b0);
            end
            exp_lock[u] = r.lock;
            if (r.valid) begin
                exp_data[u] = r.value;
                exp_idx[u]  = 16'(r.idx);
            end
            e_dv = r.valid;
            e_fd = r.fd;
            e_pe = r.pe;
        end
        if (u == 0) begin
            o_dv = a_if.data_valid; o_fd = a_if.frame_done; o_pe = a_if.parity_err;
            o_lk = a_if.sync_lock;  o_do = 16'(a_if.data_out); o_ix = 16'(a_if.word_idx);
        end else begin
            o_dv = b_if.data_valid; o_fd = b_if.frame_done; o_pe = b_if.parity_err;
            o_lk = b_if.sync_lock;  o_do = 16'(b_if.data_out); o_ix = 16'(b_if.word_idx);
        end
        if (o_dv === 1'b1) dv_seen++;
        if (o_pe === 1'b1) pe_seen++;
        check("data_valid", 16'(o_dv), 16'(e_dv));
        check("frame_done", 16'(o_fd), 16'(e_fd));
        check("parity_err", 16'(o_pe), 16'(e_pe));
        check("sync_lock", 16'(o_lk), 16'(exp_lock[u]));
        check("data_out", o_do, exp_data[u]);
        check("word_idx", o_ix, exp_idx[u]);
    endtask

    task automatic send_bit(input int u, input bit d, input bit gaps);
        if (gaps && $urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, 3)) step(u, 1'b0, 1'($urandom));
        end
        step(u, 1'b1, d);
    endtask

    task automatic send_sync(input int u, input bit gaps);
        send_bit(u, 1'b1, gaps); send_bit(u, 1'b0, gaps);
        send_bit(u, 1'b1, gaps); send_bit(u, 1'b0, gaps);
    endtask

    task automatic send_word(input int u, input logic [15:0] val, input int ww, input bit msbf,
                             input bit gaps, input bit bad_par);
        for (int i = 0; i < ww; i++) send_bit(u, msbf ? val[ww-1-i] : val[i], gaps);
        if (PAR == 1) send_bit(u, (^val[11:0]) ^ bad_par, gaps);
    endtask

    task automatic do_reset();
        a_if.bit_valid = 1'b0;
        b_if.bit_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_a_out", 16'(a_if.data_out), 16'h0);
        check("rst_a_ctl", 16'({a_if.data_valid, a_if.word_idx, a_if.frame_done, a_if.sync_lock, a_if.parity_err}), 16'h0);
        check("rst_b_out", 16'(b_if.data_out), 16'h0);
        check("rst_b_ctl", 16'({b_if.data_valid, b_if.word_idx, b_if.frame_done, b_if.sync_lock, b_if.parity_err}), 16'h0);
        hist_a.delete();
        hist_b.delete();
        for (int u = 0; u < 2; u++) begin
            exp_data[u] = '0; exp_idx[u] = '0; exp_lock[u] = 1'b0;
        end
        @(posedge t_clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        a_if.data_in = 1'b0; a_if.bit_valid = 1'b0;
        b_if.data_in = 1'b0; b_if.bit_valid = 1'b0;
        for (int u = 0; u < 2; u++) begin
            exp_data[u] = '0; exp_idx[u] = '0; exp_lock[u] = 1'b0;
        end
        #1;
        check("reset_a", 16'({a_if.data_out, a_if.data_valid, a_if.sync_lock}), 16'h0);
        check("reset_b", 16'({b_if.data_out, b_if.data_valid, b_if.sync_lock}), 16'h0);
        @(posedge t_clk);
        #1 rst = 1'b0;

        // 1: idle zeros, sync, A5 3C FF 00 MSB-first
        dv_seen = 0;
        repeat (6) step(0, 1'b1, 1'b0);
        send_sync(0, 1'b0);
        send_word(0, 16'hA5, 8, 1'b1, 1'b0, 1'b0);
        send_word(0, 16'h3C, 8, 1'b1, 1'b0, 1'b0);
        send_word(0, 16'hFF, 8, 1'b1, 1'b0, 1'b0);
        send_word(0, 16'h00, 8, 1'b1, 1'b0, 1'b0);
        repeat (3) step(0, 1'b1, 1'b0);
        check("t1_words", 16'(dv_seen), 16'd4);

        // 2: same frame with gaps
        dv_seen = 0;
        send_sync(0, 1'b1);
        send_word(0, 16'hA5, 8, 1'b1, 1'b1, 1'b0);
        send_word(0, 16'h3C, 8, 1'b1, 1'b1, 1'b0);
        send_word(0, 16'hFF, 8, 1'b1, 1'b1, 1'b0);
        send_word(0, 16'h00, 8, 1'b1, 1'b1, 1'b0);
        step(0, 1'b0, 1'b0);
        check("t2_words", 16'(dv_seen), 16'd4);

        // 3: payload containing the sync pattern, then back-to-back frame
        dv_seen = 0;
        send_sync(0, 1'b0);
        send_word(0, 16'hAA, 8, 1'b1, 1'b0, 1'b0);
        send_word(0, 16'h0A, 8, 1'b1, 1'b0, 1'b0);
        send_word(0, 16'hA0, 8, 1'b1, 1'b0, 1'b0);
        send_word(0, 16'h55, 8, 1'b1, 1'b0, 1'b0);
        send_sync(0, 1'b0);
        send_word(0, 16'h11, 8, 1'b1, 1'b0, 1'b0);
        send_word(0, 16'h22, 8, 1'b1, 1'b0, 1'b0);
        send_word(0, 16'h33, 8, 1'b1, 1'b0, 1'b0);
        send_word(0, 16'h44, 8, 1'b1, 1'b0, 1'b0);
        check("t3_words", 16'(dv_seen), 16'd8);

        // 4: reset mid-frame, then a clean frame
        send_sync(0, 1'b0);
        send_word(0, 16'h01, 8, 1'b1, 1'b0, 1'b0);
        send_word(0, 16'h02, 8, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(0, 1'b1, 1'b0);
        do_reset();
        dv_seen = 0;
        repeat (2) step(0, 1'b0, 1'b1);
        send_sync(0, 1'b0);
        send_word(0, 16'h01, 8, 1'b1, 1'b0, 1'b0);
        send_word(0, 16'h02, 8, 1'b1, 1'b0, 1'b0);
        send_word(0, 16'h03, 8, 1'b1, 1'b0, 1'b0);
        send_word(0, 16'h04, 8, 1'b1, 1'b0, 1'b0);
        check("t4_words", 16'(dv_seen), 16'd4);
        check("t4_last", 16'(a_if.data_out), 16'h04);

        // 5: 12-bit LSB-first, two words
        dv_seen = 0;
        repeat (3) step(1, 1'b1, 1'b0);
        send_sync(1, 1'b0);
        send_word(1, 16'hABC, 12, 1'b0, 1'b0, 1'b0);
        send_word(1, 16'h123, 12, 1'b0, 1'b0, 1'b0);
        step(1, 1'b0, 1'b0);
        check("t5_words", 16'(dv_seen), 16'd2);
        check("t5_last", 16'(b_if.data_out), 16'h123);

`ifdef PARITY_CHK_EN
        // 6: one corrupted parity bit
        pe_seen = 0;
        send_sync(0, 1'b0);
        send_word(0, 16'hA5, 8, 1'b1, 1'b0, 1'b0);
        send_word(0, 16'h01, 8, 1'b1, 1'b0, 1'b1);
        send_word(0, 16'h7E, 8, 1'b1, 1'b0, 1'b0);
        send_word(0, 16'h80, 8, 1'b1, 1'b0, 1'b0);
        check("t6_perr", 16'(pe_seen), 16'd1);
`endif

        // random junk, frames and gaps on both configurations
        for (int f = 0; f < 4; f++) begin
            repeat ($urandom_range(0, 6)) send_bit(0, 1'($urandom), 1'b1);
            send_sync(0, 1'b1);
            for (int w = 0; w < 4; w++)
                send_word(0, 16'($urandom_range(0, 255)), 8, 1'b1, 1'b1, 1'($urandom_range(0, 1)));
        end
        for (int f = 0; f < 2; f++) begin
            repeat ($urandom_range(0, 6)) send_bit(1, 1'($urandom), 1'b1);
            send_sync(1, 1'b1);
            for (int w = 0; w < 2; w++)
                send_word(1, 16'($urandom_range(0, 4095)), 12, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
        end
        step(0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
